// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared types and helpers for the PCIe endpoint memory-request path
//   pcie_ep_sram_state_t : scratch SRAM FSM states
//   PCIE_MEM_WORD_BYTES  : bytes per SRAM word / response beat
//   pcie_mem_beats()     : number of 64-bit beats covering a read of (addr offset, bytes)
package pcie_dma_pkg;
    typedef enum logic {IDLE, RD_BURST} pcie_ep_sram_state_t;
    localparam int PCIE_MEM_WORD_BYTES = 8;
    // A byte count of 0 encodes 1024; 11-bit arithmetic keeps 7 + 1024 + 7 in range.
    function automatic logic [10:0] pcie_mem_beats(input logic [2:0] addr, input logic [9:0] bytes);
        logic [10:0] n;
        n = (bytes == 10'd0) ? 11'd1024 : {1'b0, bytes};
        return ({8'd0, addr} + n + 11'd7) >> 3;
    endfunction
endpackage

// File: rtl/pcie_ep_sram_ram.sv
// pcie_ep_sram_ram: single-port 64-bit RAM with byte enables and 1-cycle synchronous read
//   clk_i   : clock
//   we_i    : write enable (byte-masked by be_i)
//   re_i    : read enable; rdata_o updates only on a read and holds otherwise
//   addr_i  : word address
//   be_i    : byte enables
//   wdata_i : write data
//   rdata_o : registered read data
module pcie_ep_sram_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    be_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);
    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (we_i)
            for (int i = 0; i < 8; i++)
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        if (re_i) rdata_q <= mem_q[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/pcie_ep_sram.sv
// pcie_ep_sram: BAR-backed scratch SRAM answering endpoint memory requests with 64-bit response beats
//   i_clk, i_nrst     : clock, asynchronous active-low reset
//   i_req_mem_*       : request (valid/ready, write, bytes, addr, strob, data, last)
//   o_resp_mem_*      : response (valid/ready, last, fault, addr, data)
//   PCIE_EP_SRAM_BOUNDS_EN : when defined, addresses >= MEM_SIZE_BYTES fault instead of aliasing
module pcie_ep_sram
    import pcie_dma_pkg::*;
#(
    parameter int MEM_SIZE_BYTES = 4096
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_req_mem_valid,
    output logic        o_req_mem_ready,
    input  logic        i_req_mem_write,
    input  logic [9:0]  i_req_mem_bytes,
    input  logic [12:0] i_req_mem_addr,
    input  logic [7:0]  i_req_mem_strob,
    input  logic [63:0] i_req_mem_data,
    input  logic        i_req_mem_last,
    output logic        o_resp_mem_valid,
    output logic        o_resp_mem_last,
    output logic        o_resp_mem_fault,
    output logic [12:0] o_resp_mem_addr,
    output logic [63:0] o_resp_mem_data,
    input  logic        i_resp_mem_ready
);
    localparam int WORDS = MEM_SIZE_BYTES / PCIE_MEM_WORD_BYTES;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    pcie_ep_sram_state_t state_q, state_d;
    logic [12:0] addr_q, addr_d;
    logic [10:0] beats_q, beats_d, k_q, k_d;
    logic        resp_valid_q, resp_valid_d, resp_last_q, resp_last_d;
    logic        resp_fault_q, resp_fault_d, resp_rd_q, resp_rd_d;
    logic [12:0] resp_addr_q, resp_addr_d;
    logic        can_load, req_acc, wr_acc, rd_acc, rd_issue, beat_last, req_oob, beat_oob;
    logic [9:0]  beat_word, mem_word;
    logic [12:0] beat_addr;
    logic [63:0] rdata;

    assign can_load        = !resp_valid_q || i_resp_mem_ready;
    // Gated by i_nrst so the port advertises no capacity while reset is held.
    assign o_req_mem_ready = i_nrst && (state_q == IDLE) && can_load;
    assign req_acc         = i_req_mem_valid && o_req_mem_ready;
    assign wr_acc          = req_acc && i_req_mem_write;
    assign rd_acc          = req_acc && !i_req_mem_write;
    assign rd_issue        = (state_q == RD_BURST) && can_load;
    assign beat_word       = addr_q[12:3] + k_q[9:0];
    assign beat_addr       = (k_q == 11'd0) ? addr_q : {beat_word, 3'b000};
    assign beat_last       = (k_q + 11'd1 == beats_q);
    assign mem_word        = rd_issue ? beat_addr[12:3] : i_req_mem_addr[12:3];

`ifdef PCIE_EP_SRAM_BOUNDS_EN
    localparam logic [13:0] LIMIT = 14'(MEM_SIZE_BYTES);
    assign req_oob  = {1'b0, i_req_mem_addr} >= LIMIT;
    assign beat_oob = {1'b0, beat_addr} >= LIMIT;
`else
    assign req_oob  = 1'b0;
    assign beat_oob = 1'b0;
`endif

    pcie_ep_sram_ram #(.DEPTH(WORDS), .AW(AW)) u_ram (
        .clk_i   (i_clk),
        .we_i    (wr_acc && !req_oob),
        .re_i    (rd_issue),
        .addr_i  (AW'(mem_word & 10'(WORDS - 1))),
        .be_i    (i_req_mem_strob),
        .wdata_i (i_req_mem_data),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_d      = beats_q;
        k_d          = k_q;
        resp_valid_d = resp_valid_q;
        resp_last_d  = resp_last_q;
        resp_fault_d = resp_fault_q;
        resp_addr_d  = resp_addr_q;
        resp_rd_d    = resp_rd_q;
        if (rd_acc) begin
            state_d = RD_BURST;
            addr_d  = i_req_mem_addr;
            beats_d = pcie_mem_beats(i_req_mem_addr[2:0], i_req_mem_bytes);
            k_d     = 11'd0;
        end
        if (rd_issue) begin
            k_d     = k_q + 11'd1;
            state_d = beat_last ? IDLE : RD_BURST;
        end
        if (wr_acc) begin
            resp_valid_d = 1'b1;
            resp_last_d  = i_req_mem_last;
            resp_fault_d = req_oob;
            resp_addr_d  = i_req_mem_addr;
            resp_rd_d    = 1'b0;
        end else if (rd_issue) begin
            resp_valid_d = 1'b1;
            resp_last_d  = beat_last;
            resp_fault_d = beat_oob;
            resp_addr_d  = beat_addr;
            resp_rd_d    = 1'b1;
        end else if (can_load) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beats_q      <= '0;
            k_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_rd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_q      <= beats_d;
            k_q          <= k_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
            resp_fault_q <= resp_fault_d;
            resp_addr_q  <= resp_addr_d;
            resp_rd_q    <= resp_rd_d;
        end
    end

    // The RAM read register only advances when a beat is loaded, so it doubles as the held data.
    assign o_resp_mem_valid = resp_valid_q;
    assign o_resp_mem_last  = resp_last_q;
    assign o_resp_mem_fault = resp_fault_q;
    assign o_resp_mem_addr  = resp_addr_q;
    assign o_resp_mem_data  = (resp_rd_q && !resp_fault_q) ? rdata : 64'd0;
endmodule

// File: tb/tb_pcie_ep_sram.sv
// tb_pcie_ep_sram: directed self-checking bench for pcie_ep_sram
module tb_pcie_ep_sram;
    logic        i_clk = 1'b0, i_nrst = 1'b0;
    logic        i_req_mem_valid = 1'b0, i_req_mem_write = 1'b0, i_req_mem_last = 1'b0;
    logic [9:0]  i_req_mem_bytes = '0;
    logic [12:0] i_req_mem_addr = '0;
    logic [7:0]  i_req_mem_strob = '0;
    logic [63:0] i_req_mem_data = '0;
    logic        i_resp_mem_ready = 1'b1;
    logic        o_req_mem_ready, o_resp_mem_valid, o_resp_mem_last, o_resp_mem_fault;
    logic [12:0] o_resp_mem_addr;
    logic [63:0] o_resp_mem_data;

    int checks = 0, errors = 0;
    logic [12:0] b_addr [256];
    logic [63:0] b_data [256];
    logic        b_last [256];
    logic        b_fault [256];
    int          b_cyc [256];
    int          nb, rq_bad;

    pcie_ep_sram #(.MEM_SIZE_BYTES(4096)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_req_mem_valid(i_req_mem_valid), .o_req_mem_ready(o_req_mem_ready),
        .i_req_mem_write(i_req_mem_write), .i_req_mem_bytes(i_req_mem_bytes),
        .i_req_mem_addr(i_req_mem_addr), .i_req_mem_strob(i_req_mem_strob),
        .i_req_mem_data(i_req_mem_data), .i_req_mem_last(i_req_mem_last),
        .o_resp_mem_valid(o_resp_mem_valid), .o_resp_mem_last(o_resp_mem_last),
        .o_resp_mem_fault(o_resp_mem_fault), .o_resp_mem_addr(o_resp_mem_addr),
        .o_resp_mem_data(o_resp_mem_data), .i_resp_mem_ready(i_resp_mem_ready)
    );

    always #5 i_clk = ~i_clk;

    // Returns at posedge+1 of the cycle after acceptance (write response visible, read burst starting).
    task automatic send_req(input logic wr, input logic [12:0] addr, input logic [9:0] bytes,
                            input logic [7:0] strob, input logic [63:0] data, input logic last);
        bit done = 0;
        @(negedge i_clk);
        i_req_mem_valid = 1'b1; i_req_mem_write = wr; i_req_mem_addr = addr;
        i_req_mem_bytes = bytes; i_req_mem_strob = strob; i_req_mem_data = data; i_req_mem_last = last;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (o_req_mem_ready) begin @(posedge i_clk); #1; done = 1; end
            else @(negedge i_clk);
        end
        i_req_mem_valid = 1'b0;
        if (!done) begin checks++; errors++; $display("FAIL req_accept: ready never seen for addr %h", addr); end
    endtask

    // Records accepted beats; cycle 1 is the first cycle after the read was accepted.
    task automatic collect(input bit toggle);
        bit seen_last = 0;
        int tail = 0;
        nb = 0; rq_bad = 0;
        for (int c = 1; c < 400; c++) begin
            @(negedge i_clk);
            i_resp_mem_ready = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (!seen_last && !(o_resp_mem_valid && o_resp_mem_last) && o_req_mem_ready) rq_bad++;
            if (o_resp_mem_valid && i_resp_mem_ready) begin
                if (nb < 256) begin
                    b_addr[nb] = o_resp_mem_addr; b_data[nb] = o_resp_mem_data;
                    b_last[nb] = o_resp_mem_last; b_fault[nb] = o_resp_mem_fault; b_cyc[nb] = c;
                end
                nb++;
                if (o_resp_mem_last) seen_last = 1;
            end
            if (seen_last) tail++;
            if (tail > 4) break;
        end
        i_resp_mem_ready = 1'b1;
    endtask

    task automatic test_reset;
        int bad = 0;
        repeat (3) @(negedge i_clk);
        #1;
        checks++; if (o_resp_mem_valid !== 1'b0) begin errors++; $display("FAIL por_valid: got %b exp 0", o_resp_mem_valid); end
        checks++; if (o_req_mem_ready !== 1'b0) begin errors++; $display("FAIL por_ready: got %b exp 0", o_req_mem_ready); end
        checks++; if ({o_resp_mem_last, o_resp_mem_fault, o_resp_mem_addr, o_resp_mem_data} !== 79'd0) begin
            errors++; $display("FAIL por_resp: got %b/%b/%h/%h exp all 0", o_resp_mem_last, o_resp_mem_fault, o_resp_mem_addr, o_resp_mem_data); end
        @(negedge i_clk); i_nrst = 1'b1;
        #1;
        checks++; if (o_req_mem_ready !== 1'b1) begin errors++; $display("FAIL por_release_ready: got %b exp 1", o_req_mem_ready); end
        send_req(1'b0, 13'h000, 10'd0, 8'h00, 64'd0, 1'b0);
        repeat (4) @(negedge i_clk);
        #1;
        checks++; if (o_resp_mem_valid !== 1'b1) begin errors++; $display("FAIL midburst_valid: got %b exp 1", o_resp_mem_valid); end
        i_nrst = 1'b0;
        #1;
        checks++; if (o_resp_mem_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b exp 0", o_resp_mem_valid); end
        checks++; if (o_req_mem_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b exp 0", o_req_mem_ready); end
        repeat (2) @(negedge i_clk);
        i_nrst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk); #1;
            if (o_resp_mem_valid !== 1'b0 || o_req_mem_ready !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL post_reset_idle: %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_write_read;
        send_req(1'b1, 13'h010, 10'd0, 8'hFF, 64'd0, 1'b1);
        checks++; if ({o_resp_mem_valid, o_resp_mem_fault, o_resp_mem_last} !== 3'b101) begin
            errors++; $display("FAIL wr0_resp: got v/f/l %b%b%b exp 101", o_resp_mem_valid, o_resp_mem_fault, o_resp_mem_last); end
        send_req(1'b1, 13'h010, 10'd0, 8'h0F, 64'h1122334455667788, 1'b0);
        checks++; if ({o_resp_mem_valid, o_resp_mem_fault, o_resp_mem_last} !== 3'b100) begin
            errors++; $display("FAIL wr1_resp: got v/f/l %b%b%b exp 100", o_resp_mem_valid, o_resp_mem_fault, o_resp_mem_last); end
        checks++; if (o_resp_mem_addr !== 13'h010 || o_resp_mem_data !== 64'd0) begin
            errors++; $display("FAIL wr1_addr_data: got %h/%h exp 0010/0", o_resp_mem_addr, o_resp_mem_data); end
        send_req(1'b0, 13'h010, 10'd8, 8'h00, 64'd0, 1'b0);
        collect(1'b0);
        checks++; if (nb !== 1) begin errors++; $display("FAIL rd_count: got %0d exp 1", nb); end
        checks++; if (b_cyc[0] !== 2) begin errors++; $display("FAIL rd_latency: got cycle %0d exp 2", b_cyc[0]); end
        checks++; if (b_data[0] !== 64'h0000000055667788) begin errors++; $display("FAIL rd_data: got %h exp 0000000055667788", b_data[0]); end
        checks++; if ({b_last[0], b_fault[0], b_addr[0]} !== {2'b10, 13'h010}) begin
            errors++; $display("FAIL rd_meta: got l/f/a %b/%b/%h exp 1/0/0010", b_last[0], b_fault[0], b_addr[0]); end
    endtask

    task automatic test_unaligned;
        send_req(1'b0, 13'h004, 10'd12, 8'h00, 64'd0, 1'b0);
        collect(1'b0);
        checks++; if (nb !== 2) begin errors++; $display("FAIL unal_count: got %0d exp 2", nb); end
        checks++; if (b_addr[0] !== 13'h004 || b_addr[1] !== 13'h008) begin
            errors++; $display("FAIL unal_addr: got %h,%h exp 0004,0008", b_addr[0], b_addr[1]); end
        checks++; if (b_last[0] !== 1'b0 || b_last[1] !== 1'b1) begin
            errors++; $display("FAIL unal_last: got %b,%b exp 0,1", b_last[0], b_last[1]); end
    endtask

    task automatic test_max_len;
        int bad = 0;
        send_req(1'b0, 13'h000, 10'd0, 8'h00, 64'd0, 1'b0);
        collect(1'b0);
        checks++; if (nb !== 128) begin errors++; $display("FAIL max_count: got %0d exp 128", nb); end
        for (int k = 0; k < 128; k++)
            if (b_addr[k] !== 13'(k * 8) || b_cyc[k] !== k + 2 || b_last[k] !== (k == 127)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL max_contig: %0d bad beats exp 0", bad); end
    endtask

    task automatic test_back_to_back;
        int bad = 0;
        @(negedge i_clk);
        for (int i = 0; i < 4; i++) begin
            i_req_mem_valid = 1'b1; i_req_mem_write = 1'b1; i_req_mem_addr = 13'(13'h200 + 8 * i);
            i_req_mem_strob = 8'hFF; i_req_mem_data = 64'hB0B0_0000_0000_0000 + 64'(i); i_req_mem_last = (i == 3);
            #1;
            if (o_req_mem_ready !== 1'b1) bad++;
            @(posedge i_clk); #1;
            if (o_resp_mem_valid !== 1'b1 || o_resp_mem_addr !== 13'(13'h200 + 8 * i) || o_resp_mem_last !== (i == 3)) bad++;
            @(negedge i_clk);
        end
        i_req_mem_valid = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_writes: %0d bad beats exp 0", bad); end
        send_req(1'b0, 13'h200, 10'd32, 8'h00, 64'd0, 1'b0);
        collect(1'b0);
        bad = 0;
        for (int k = 0; k < 4; k++) if (b_data[k] !== 64'hB0B0_0000_0000_0000 + 64'(k)) bad++;
        checks++; if (nb !== 4 || bad !== 0) begin errors++; $display("FAIL b2b_readback: got %0d beats, %0d bad exp 4, 0", nb, bad); end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        for (int i = 0; i < 16; i++) send_req(1'b1, 13'(13'h100 + 8 * i), 10'd0, 8'hFF, 64'hA000 + 64'(i), 1'b1);
        send_req(1'b0, 13'h100, 10'd128, 8'h00, 64'd0, 1'b0);
        collect(1'b1);
        checks++; if (nb !== 16) begin errors++; $display("FAIL bp_count: got %0d exp 16", nb); end
        for (int k = 0; k < 16; k++)
            if (b_addr[k] !== 13'(13'h100 + 8 * k) || b_data[k] !== 64'hA000 + 64'(k) || b_last[k] !== (k == 15)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_order: %0d bad beats exp 0", bad); end
        checks++; if (rq_bad !== 0) begin errors++; $display("FAIL bp_req_ready: high in %0d burst cycles exp 0", rq_bad); end
    endtask

    task automatic test_bounds;
        send_req(1'b1, 13'h000, 10'd0, 8'hFF, 64'h0123456789ABCDEF, 1'b1);
`ifdef PCIE_EP_SRAM_BOUNDS_EN
        send_req(1'b0, 13'hFF8, 10'd16, 8'h00, 64'd0, 1'b0);
        collect(1'b0);
        checks++; if (nb !== 2) begin errors++; $display("FAIL bnd_count: got %0d exp 2", nb); end
        checks++; if (b_fault[0] !== 1'b0 || b_fault[1] !== 1'b1) begin
            errors++; $display("FAIL bnd_fault: got %b,%b exp 0,1", b_fault[0], b_fault[1]); end
        checks++; if (b_addr[1] !== 13'h1000 || b_data[1] !== 64'd0) begin
            errors++; $display("FAIL bnd_beat1: got %h/%h exp 1000/0", b_addr[1], b_data[1]); end
        send_req(1'b1, 13'h1000, 10'd0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        checks++; if (o_resp_mem_fault !== 1'b1) begin errors++; $display("FAIL bnd_wr_fault: got %b exp 1", o_resp_mem_fault); end
        send_req(1'b0, 13'h000, 10'd8, 8'h00, 64'd0, 1'b0);
        collect(1'b0);
        checks++; if (b_data[0] !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL bnd_word0: got %h exp 0123456789abcdef", b_data[0]); end
`else
        send_req(1'b1, 13'h1000, 10'd0, 8'hFF, 64'hDEAD_BEEF_0000_1111, 1'b1);
        checks++; if (o_resp_mem_fault !== 1'b0) begin errors++; $display("FAIL alias_wr_fault: got %b exp 0", o_resp_mem_fault); end
        send_req(1'b0, 13'h000, 10'd8, 8'h00, 64'd0, 1'b0);
        collect(1'b0);
        checks++; if (b_data[0] !== 64'hDEAD_BEEF_0000_1111 || b_fault[0] !== 1'b0) begin
            errors++; $display("FAIL alias_word0: got %h/%b exp deadbeef00001111/0", b_data[0], b_fault[0]); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_unaligned();
        test_max_len();
        test_back_to_back();
        test_backpressure();
        test_bounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
